alu_unit: RTL and testbench
===========================

// Module: alu_unit
// PURPOSE
//   32-bit integer ALU for the RV32I execute stage; computes arithmetic, logic, shift, compare
//   and branch-condition results selected by a 6-bit control code.
//   Result is registered: one clock of latency between operand/control capture and ALU_result.
//   Sits between decode/operand-select and the writeback/branch logic.
// PARAMETERS
//   DATA_WIDTH  32  operand/result width (only 32 is required to be supported)
// PORTS
//   clock        in   1   single clock; all state updates on rising edge
//   reset_n      in   1   asynchronous, active-low reset
//   ALU_Control  in   6   operation select (encodings below)
//   operand_A    in   32  first operand (rs1 / PC)
//   operand_B    in   32  second operand (rs2 / immediate)
//   ALU_result   out  32  registered result
// BEHAVIOUR
//   - Reset: reset_n low clears ALU_result to 32'h0 immediately (async); held while low.
//   - Each rising clock with reset_n high: ALU_result <= f(ALU_Control, operand_A, operand_B)
//     using values present before the edge; latency exactly 1 cycle, no stall/enable.
//   - Encodings (ALU_Control[5:0]), arithmetic mod 2^32, no overflow/carry flags:
//       000000 ADD  A+B              001000 SUB  A-B
//       000001 SLL  A << B[4:0]      000101 SRL  A >> B[4:0] (zero fill)
//       001101 SRA  A >>> B[4:0] (sign fill)
//       000010 SLT  signed A<B -> 1 else 0      000011 SLTU unsigned A<B -> 1 else 0
//       000100 XOR  A^B    000110 OR  A|B    000111 AND  A&B
//       010000 BEQ  A==B  -> 1/0              010001 BNE  A!=B -> 1/0
//       010100 BLT  signed A<B                010101 BGE  signed A>=B
//       010110 BLTU unsigned A<B              010111 BGEU unsigned A>=B
//       011111 PASS A (JAL/JALR link path)
//     Compare/branch ops return 32'h0000_0001 or 32'h0000_0000.
//   - Any other code: result 32'h0.
//   - Shift amounts use only B[4:0]; B[31:5] ignored. Shift by 0 returns A unchanged.
//   - Signed ops treat bit 31 as sign: SLT(4, 32'hFFFF_FFFF) = 0; SLTU same operands = 1.
//   - Control change and operand change in the same cycle: both take effect together next edge.
//   - Reset deasserting mid-stream: first edge after release registers the current inputs.
// STRUCTURE
//   - alu_pkg: localparams for all ALU_Control encodings, DATA_WIDTH default.
//   - One sub-module natural: alu_shifter (SLL/SRL/SRA, 5-bit shamt, arith flag).
//   - Top: combinational case on ALU_Control into next_result, then async-reset output register.
// TESTING
//   1. Reset low, any inputs -> ALU_result 0; release, ADD 4,5 -> 9 one edge later.
//   2. SLT 4,5 -> 1; SLT 4,32'hFFFFFFFF -> 0; SLTU 4,32'hFFFFFFFF -> 1; SLT 1,32'hC -> 1.
//   3. AND 32'hDEADBEEF,32'h0000FFFF -> 32'h0000BEEF; XOR same -> 32'hDEAD4110; OR -> 32'hDEADFFFF.
//   4. SUB 0,1 -> 32'hFFFFFFFF; ADD 32'hFFFFFFFF,1 -> 0 (wrap).
//   5. SRA 32'h80000000,B=32'h21 (shamt 1) -> 32'hC0000000; SRL -> 32'h40000000; SLL 1,31 -> 32'h80000000.
//   6. BEQ 7,7 -> 1; BGE -1,0 -> 0; BGEU -1,0 -> 1; code 6'b111111 -> 0; reset asserted mid-run clears output without a clock.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the RV32I execute-stage ALU: data width and control encodings.
package alu_pkg;

  localparam int unsigned ALU_DATA_WIDTH = 32;
  localparam int unsigned ALU_CTRL_W     = 6;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = 6'b000000;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = 6'b000001;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = 6'b000010;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = 6'b000011;
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = 6'b000100;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = 6'b000101;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR   = 6'b000110;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND  = 6'b000111;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = 6'b001000;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRA  = 6'b001101;
  localparam logic [ALU_CTRL_W-1:0] ALU_BEQ  = 6'b010000;
  localparam logic [ALU_CTRL_W-1:0] ALU_BNE  = 6'b010001;
  localparam logic [ALU_CTRL_W-1:0] ALU_BLT  = 6'b010100;
  localparam logic [ALU_CTRL_W-1:0] ALU_BGE  = 6'b010101;
  localparam logic [ALU_CTRL_W-1:0] ALU_BLTU = 6'b010110;
  localparam logic [ALU_CTRL_W-1:0] ALU_BGEU = 6'b010111;
  localparam logic [ALU_CTRL_W-1:0] ALU_PASS = 6'b011111;

endpackage : alu_pkg

// File: rtl/alu_shifter.sv
// Barrel shifter for SLL/SRL/SRA; right shifts share one path with a selectable fill bit.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = ALU_DATA_WIDTH,
  parameter int unsigned SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [SHAMT_W-1:0]    shamt,
  input  logic                  left,
  input  logic                  arith,
  output logic [DATA_WIDTH-1:0] shift_result_c
);

  logic signed [DATA_WIDTH:0] ext;
  logic signed [DATA_WIDTH:0] right;

  // Extend by one fill bit so a single arithmetic shift covers both SRL and SRA.
  always_comb begin
    ext            = {arith & data_in[DATA_WIDTH-1], data_in};
    right          = ext >>> shamt;
    shift_result_c = left ? (data_in << shamt) : right[DATA_WIDTH-1:0];
  end

endmodule : alu_shifter

// File: rtl/alu_unit.sv
// RV32I execute-stage ALU with a single registered result (one cycle latency).
module alu_unit
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = ALU_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [ALU_CTRL_W-1:0] ALU_Control,
  input  logic [DATA_WIDTH-1:0] operand_A,
  input  logic [DATA_WIDTH-1:0] operand_B,
  output logic [DATA_WIDTH-1:0] ALU_result
);

  localparam int unsigned SHAMT_W = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] result_d;
  logic [DATA_WIDTH-1:0] result_q;
  logic [DATA_WIDTH-1:0] shift_c;
  logic                  lt_s;
  logic                  lt_u;
  logic                  eq;

  alu_shifter #(
    .DATA_WIDTH (DATA_WIDTH),
    .SHAMT_W    (SHAMT_W)
  ) u_shifter (
    .data_in        (operand_A),
    .shamt          (operand_B[SHAMT_W-1:0]),
    .left           (ALU_Control == ALU_SLL),
    .arith          (ALU_Control == ALU_SRA),
    .shift_result_c (shift_c)
  );

  // Shared comparators feed both SLT* and branch-condition codes.
  always_comb begin
    lt_s = $signed(operand_A) < $signed(operand_B);
    lt_u = operand_A < operand_B;
    eq   = operand_A == operand_B;
  end

  // Next-result select; unlisted codes fall through to zero.
  always_comb begin
    result_d = '0;
    case (ALU_Control)
      ALU_ADD:  result_d = operand_A + operand_B;
      ALU_SUB:  result_d = operand_A - operand_B;
      ALU_SLL,
      ALU_SRL,
      ALU_SRA:  result_d = shift_c;
      ALU_SLT:  result_d = DATA_WIDTH'(lt_s);
      ALU_SLTU: result_d = DATA_WIDTH'(lt_u);
      ALU_XOR:  result_d = operand_A ^ operand_B;
      ALU_OR:   result_d = operand_A | operand_B;
      ALU_AND:  result_d = operand_A & operand_B;
      ALU_BEQ:  result_d = DATA_WIDTH'(eq);
      ALU_BNE:  result_d = DATA_WIDTH'(!eq);
      ALU_BLT:  result_d = DATA_WIDTH'(lt_s);
      ALU_BGE:  result_d = DATA_WIDTH'(!lt_s);
      ALU_BLTU: result_d = DATA_WIDTH'(lt_u);
      ALU_BGEU: result_d = DATA_WIDTH'(!lt_u);
      ALU_PASS: result_d = operand_A;
      default:  result_d = '0;
    endcase
  end

  // Output register, cleared asynchronously.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      result_q <= '0;
    end else begin
      result_q <= result_d;
    end
  end

  assign ALU_result = result_q;

endmodule : alu_unit

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed vectors plus randomized model comparison.
module tb_alu_unit;

  logic        clock;
  logic        reset_n;
  logic [5:0]  ALU_Control;
  logic [31:0] operand_A;
  logic [31:0] operand_B;
  logic [31:0] ALU_result;

  int n_tests;
  int n_fail;

  alu_unit dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .ALU_Control (ALU_Control),
    .operand_A   (operand_A),
    .operand_B   (operand_B),
    .ALU_result  (ALU_result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model computed directly from the operation definitions.
  function automatic logic [31:0] ref_alu(input logic [5:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned s;
    logic [31:0] fill;
    logic        slt;
    logic        sltu;
    s    = b % 32;
    sltu = a < b;
    slt  = (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000);
    fill = a[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0;
    case (c)
      6'b000000: return a + b;
      6'b001000: return a - b;
      6'b000001: return a << s;
      6'b000101: return a >> s;
      6'b001101: return (a >> s) | fill;
      6'b000010: return slt ? 32'd1 : 32'd0;
      6'b000011: return sltu ? 32'd1 : 32'd0;
      6'b000100: return a ^ b;
      6'b000110: return a | b;
      6'b000111: return a & b;
      6'b010000: return (a == b) ? 32'd1 : 32'd0;
      6'b010001: return (a != b) ? 32'd1 : 32'd0;
      6'b010100: return slt ? 32'd1 : 32'd0;
      6'b010101: return slt ? 32'd0 : 32'd1;
      6'b010110: return sltu ? 32'd1 : 32'd0;
      6'b010111: return sltu ? 32'd0 : 32'd1;
      6'b011111: return a;
      default:   return 32'h0;
    endcase
  endfunction

  // Drive inputs on the falling edge, then step past the next rising edge.
  task automatic apply(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    ALU_Control = c;
    operand_A   = a;
    operand_B   = b;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n     = 1'b0;
    ALU_Control = 6'b000000;
    operand_A   = $urandom;
    operand_B   = $urandom;
    #1;
    n_tests++;
    if (ALU_result !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_initial got=%h exp=%h", ALU_result, 32'h0);
    end
    repeat (3) @(posedge clock);
    #1;
    n_tests++;
    if (ALU_result !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_held got=%h exp=%h", ALU_result, 32'h0);
    end
    @(negedge clock);
    reset_n     = 1'b1;
    ALU_Control = 6'b000000;
    operand_A   = 32'd4;
    operand_B   = 32'd5;
    #1;
    n_tests++;
    if (ALU_result !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_release_no_edge got=%h exp=%h", ALU_result, 32'h0);
    end
    @(posedge clock);
    #1;
    n_tests++;
    if (ALU_result !== 32'd9) begin
      n_fail++;
      $display("FAIL reset_first_add got=%h exp=%h", ALU_result, 32'd9);
    end
  endtask

  task automatic test_directed();
    logic [5:0]  c [20];
    logic [31:0] a [20];
    logic [31:0] b [20];
    logic [31:0] e [20];
    c[0]  = 6'b000010; a[0]  = 32'd4;         b[0]  = 32'd5;         e[0]  = 32'd1;
    c[1]  = 6'b000010; a[1]  = 32'd4;         b[1]  = 32'hFFFF_FFFF; e[1]  = 32'd0;
    c[2]  = 6'b000011; a[2]  = 32'd4;         b[2]  = 32'hFFFF_FFFF; e[2]  = 32'd1;
    c[3]  = 6'b000010; a[3]  = 32'd1;         b[3]  = 32'hC;         e[3]  = 32'd1;
    c[4]  = 6'b000111; a[4]  = 32'hDEAD_BEEF; b[4]  = 32'h0000_FFFF; e[4]  = 32'h0000_BEEF;
    c[5]  = 6'b000100; a[5]  = 32'hDEAD_BEEF; b[5]  = 32'h0000_FFFF; e[5]  = 32'hDEAD_4110;
    c[6]  = 6'b000110; a[6]  = 32'hDEAD_BEEF; b[6]  = 32'h0000_FFFF; e[6]  = 32'hDEAD_FFFF;
    c[7]  = 6'b001000; a[7]  = 32'd0;         b[7]  = 32'd1;         e[7]  = 32'hFFFF_FFFF;
    c[8]  = 6'b000000; a[8]  = 32'hFFFF_FFFF; b[8]  = 32'd1;         e[8]  = 32'h0;
    c[9]  = 6'b001101; a[9]  = 32'h8000_0000; b[9]  = 32'h21;        e[9]  = 32'hC000_0000;
    c[10] = 6'b000101; a[10] = 32'h8000_0000; b[10] = 32'h21;        e[10] = 32'h4000_0000;
    c[11] = 6'b000001; a[11] = 32'd1;         b[11] = 32'd31;        e[11] = 32'h8000_0000;
    c[12] = 6'b010000; a[12] = 32'd7;         b[12] = 32'd7;         e[12] = 32'd1;
    c[13] = 6'b010101; a[13] = 32'hFFFF_FFFF; b[13] = 32'd0;         e[13] = 32'd0;
    c[14] = 6'b010111; a[14] = 32'hFFFF_FFFF; b[14] = 32'd0;         e[14] = 32'd1;
    c[15] = 6'b111111; a[15] = 32'h1234_5678; b[15] = 32'h9ABC_DEF0; e[15] = 32'h0;
    c[16] = 6'b001101; a[16] = 32'hF000_000F; b[16] = 32'hFFFF_FFE0; e[16] = 32'hF000_000F;
    c[17] = 6'b011111; a[17] = 32'hCAFE_F00D; b[17] = 32'h5;         e[17] = 32'hCAFE_F00D;
    c[18] = 6'b010001; a[18] = 32'd7;         b[18] = 32'd7;         e[18] = 32'd0;
    c[19] = 6'b010100; a[19] = 32'h8000_0000; b[19] = 32'h7FFF_FFFF; e[19] = 32'd1;
    for (int i = 0; i < 20; i++) begin
      apply(c[i], a[i], b[i]);
      n_tests++;
      if (ALU_result !== e[i]) begin
        n_fail++;
        $display("FAIL directed_%0d ctrl=%b a=%h b=%h got=%h exp=%h",
                 i, c[i], a[i], b[i], ALU_result, e[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [5:0]  codes [17];
    logic [5:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    codes = '{6'b000000, 6'b001000, 6'b000001, 6'b000101, 6'b001101, 6'b000010,
              6'b000011, 6'b000100, 6'b000110, 6'b000111, 6'b010000, 6'b010001,
              6'b010100, 6'b010101, 6'b010110, 6'b010111, 6'b011111};
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) c = 6'($urandom);
      else c = codes[$urandom_range(0, 16)];
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 5) == 0) b = a;
      if ($urandom_range(0, 5) == 0) a = {1'b1, 31'($urandom)};
      exp = ref_alu(c, a, b);
      apply(c, a, b);
      n_tests++;
      if (ALU_result !== exp) begin
        n_fail++;
        $display("FAIL random_%0d ctrl=%b a=%h b=%h got=%h exp=%h",
                 i, c, a, b, ALU_result, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] prev;
    logic [31:0] exp;
    logic [5:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    prev = ALU_result;
    for (int i = 0; i < 10; i++) begin
      c = (i % 2 == 0) ? 6'b000000 : 6'b001000;
      a = $urandom;
      b = $urandom;
      exp = ref_alu(c, a, b);
      @(negedge clock);
      ALU_Control = c;
      operand_A   = a;
      operand_B   = b;
      #1;
      n_tests++;
      if (ALU_result !== prev) begin
        n_fail++;
        $display("FAIL b2b_hold_%0d got=%h exp=%h", i, ALU_result, prev);
      end
      @(posedge clock);
      #1;
      n_tests++;
      if (ALU_result !== exp) begin
        n_fail++;
        $display("FAIL b2b_update_%0d got=%h exp=%h", i, ALU_result, exp);
      end
      prev = exp;
    end
  endtask

  task automatic test_midrun_reset();
    apply(6'b011111, 32'hA5A5_5A5A, 32'h0);
    n_tests++;
    if (ALU_result !== 32'hA5A5_5A5A) begin
      n_fail++;
      $display("FAIL midrun_preload got=%h exp=%h", ALU_result, 32'hA5A5_5A5A);
    end
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (ALU_result !== 32'h0) begin
      n_fail++;
      $display("FAIL midrun_async_clear got=%h exp=%h", ALU_result, 32'h0);
    end
    repeat (2) @(posedge clock);
    #1;
    n_tests++;
    if (ALU_result !== 32'h0) begin
      n_fail++;
      $display("FAIL midrun_reset_held got=%h exp=%h", ALU_result, 32'h0);
    end
    @(negedge clock);
    reset_n     = 1'b1;
    ALU_Control = 6'b000100;
    operand_A   = 32'hF0F0_1234;
    operand_B   = 32'h0F0F_4321;
    @(posedge clock);
    #1;
    n_tests++;
    if (ALU_result !== 32'hFFFF_5115) begin
      n_fail++;
      $display("FAIL midrun_release_first got=%h exp=%h", ALU_result, 32'hFFFF_5115);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_midrun_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_alu_unit
